// File: rtl/key_pkg.sv
// Shared types and helpers for the push-button debounce block.
// Holds the per-key filter state encoding and the debounce window calculation.
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_FILT = 2'd1,
    PRESSED    = 2'd2,
    REL_FILT   = 2'd3
  } key_state_e;

  // Debounce window in sys_clk cycles; CLK_FREQ_HZ is assumed to be a whole number of MHz.
  function automatic int deb_cycles(input int clk_freq_hz, input int debounce_us);
    return (clk_freq_hz / 1_000_000) * debounce_us;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounced key channel: 2-flop synchroniser, stability counter,
// four-state filter FSM and registered press/release pulses.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEB_CYCLES     = 1_000_000,
  parameter int CNT_W          = 20,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam logic             REL_PIN = (KEY_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             key_s;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // Synchroniser resets to the idle pin level so reset never looks like a press.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1_q <= REL_PIN;
      sync2_q <= REL_PIN;
    end else begin
      // NOTE: non-blocking here so sync2_q takes the previous sync1_q, giving two real flop stages.
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  assign key_s = (KEY_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block is given a value before the case, so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    unique case (state_q)
      RELEASED: begin
        if (key_s) begin
          state_d = PRESS_FILT;
          cnt_d   = '0;
        end
      end

      PRESS_FILT: begin
        if (!key_s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      PRESSED: begin
        if (!key_s) begin
          state_d = REL_FILT;
          cnt_d   = '0;
        end
      end

      REL_FILT: begin
        if (key_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: rtl/key_debounce.sv
// N-channel push-button debouncer: independent filter per key, registered
// levels (pressed = 1) and single-cycle press/release pulses.
module key_debounce
  import key_pkg::*;
#(
  parameter int KEY_NUM        = 4,
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int DEBOUNCE_US    = 20_000,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release
);

  localparam int DEB_CYCLES = deb_cycles(CLK_FREQ_HZ, DEBOUNCE_US);
  localparam int CNT_W      = $clog2(DEB_CYCLES + 1);

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    key_debounce_ch #(
      .DEB_CYCLES    (DEB_CYCLES),
      .CNT_W         (CNT_W),
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) u_ch (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .key_in     (key_in[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i])
    );
  end

endmodule
